// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
package seq_detect_pkg;

    localparam int SEQ_MAX_LEN_DEF = 8;
    localparam int SEQ_CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_FILL     = 2'd1,
        ST_ARMED    = 2'd2
    } seq_state_e;

    // Width needed to hold a pattern length in 0..max_len.
    function automatic int seq_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating counter with synchronous clear; with W=1 and CLR_WINS=0 it doubles
// as a sticky flag whose set beats a simultaneous clear.
module seq_match_cnt #(
    parameter int W        = 8,
    parameter bit CLR_WINS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i && (CLR_WINS || !inc_i))
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial sequence detector with match pulse and counter.
// Optional sticky match interrupt enabled by defining SEQ_DETECT_IRQ_EN.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN = SEQ_MAX_LEN_DEF,
    parameter int                 CNT_W   = SEQ_CNT_W_DEF,
    parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'b0000_1110),
    parameter int                 LEN_W   = seq_len_w(MAX_LEN),
    parameter logic [LEN_W-1:0]   RST_LEN = LEN_W'(5),
    parameter bit                 RST_OVL = 1'b1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               din_vld,
    input  logic               din,
    input  logic               cnt_clr,
    output logic               Z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
`ifdef SEQ_DETECT_IRQ_EN
    ,
    input  logic               irq_clr,
    output logic               irq
`endif
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_n;
    seq_state_e         state_q, state_d;
    logic               z_q;
    logic               match;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_clamped;

    // Only the low len bits of history take part in the compare.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_q));
    end

    assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign hist_n      = MAX_LEN'({hist_q, din});
    assign fill_n      = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        match   = 1'b0;
        if (cfg_we) begin
            // The din_vld bit arriving with a config write is intentionally dropped.
            pat_d   = cfg_pat;
            len_d   = len_clamped;
            ovl_d   = cfg_ovl;
            hist_d  = '0;
            fill_d  = '0;
            state_d = (len_clamped == '0) ? ST_DISABLED : ST_FILL;
        end else if (din_vld && (state_q != ST_DISABLED)) begin
            hist_d = hist_n;
            fill_d = fill_n;
            match  = (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);
            if (match && !ovl_q) begin
                fill_d  = '0;
                state_d = ST_FILL;
            end else begin
                state_d = (fill_n >= len_q) ? ST_ARMED : ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pat_q   <= RST_PAT;
            len_q   <= RST_LEN;
            ovl_q   <= RST_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= (RST_LEN == '0) ? ST_DISABLED : ST_FILL;
            z_q     <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            z_q     <= match;
        end
    end

    seq_match_cnt #(.W(CNT_W), .CLR_WINS(1'b1)) u_cnt (
        .clk   (clk),
        .rst_n (clr),
        .clr_i (cnt_clr),
        .inc_i (match),
        .cnt_o (match_cnt)
    );

`ifdef SEQ_DETECT_IRQ_EN
    seq_match_cnt #(.W(1), .CLR_WINS(1'b0)) u_irq (
        .clk   (clk),
        .rst_n (clr),
        .clr_i (irq_clr),
        .inc_i (match),
        .cnt_o (irq)
    );
`endif

    assign Z     = z_q;
    assign armed = (state_q == ST_ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: vector table plus hand-written reset/irq sequences.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_seq_detect_param;
    import seq_detect_pkg::*;

    localparam int ML = 8;
    localparam int LW = seq_len_w(ML);
    localparam logic [7:0] P0 = 8'b0000_1110;

    logic          clk = 1'b0, clr = 1'b0;
    logic          cfg_we = 1'b0, cfg_ovl = 1'b0, din_vld = 1'b0, din = 1'b0;
    logic          cnt_clr = 1'b0, irq_clr = 1'b0;
    logic [ML-1:0] cfg_pat = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          z1, z2, a1, a2;
    logic [7:0]    c1;
    logic [1:0]    c2;
    logic          q1, q2;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .clr(clr), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .din_vld(din_vld), .din(din), .cnt_clr(cnt_clr),
        .Z(z1), .match_cnt(c1), .armed(a1)
`ifdef SEQ_DETECT_IRQ_EN
        , .irq_clr(irq_clr), .irq(q1)
`endif
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .clr(clr), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .din_vld(din_vld), .din(din), .cnt_clr(cnt_clr),
        .Z(z2), .match_cnt(c2), .armed(a2)
`ifdef SEQ_DETECT_IRQ_EN
        , .irq_clr(irq_clr), .irq(q2)
`endif
    );

`ifndef SEQ_DETECT_IRQ_EN
    assign q1 = 1'b0;
    assign q2 = 1'b0;
`endif

    typedef struct {
        logic       we;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl, vld, din, cclr, ez, ea;
        int         ecnt;
    } vec_t;

    typedef struct {
        logic z, a, irq;
        int   cnt, cnt2;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0, failures = 0, step = 0;
    int   m2 = 0;
    logic irq_m = 1'b0;

    function automatic vec_t V(logic we, logic [7:0] pat, logic [3:0] len, logic ovl,
                               logic vld, logic d, logic cclr, logic ez, logic ea, int ecnt);
        vec_t v;
        v.we = we; v.pat = pat; v.len = len; v.ovl = ovl; v.vld = vld; v.din = d;
        v.cclr = cclr; v.ez = ez; v.ea = ea; v.ecnt = ecnt;
        return v;
    endfunction

    function automatic vec_t D(logic d, logic ez, logic ea, int ecnt);
        return V(0, 8'h00, 4'd0, 0, 1, d, 0, ez, ea, ecnt);
    endfunction

    function automatic vec_t G(logic d, logic ea, int ecnt);
        return V(0, 8'h00, 4'd0, 0, 0, d, 0, 0, ea, ecnt);
    endfunction

    function automatic vec_t C(logic [7:0] pat, logic [3:0] len, logic ovl, int ecnt);
        return V(1, pat, len, ovl, 1, 1, 0, 0, 0, ecnt);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d expected=%0d", nm, step, act, exp);
        end
    endtask

    task automatic cyc(input vec_t v);
        exp_t e;
        step++;
        cfg_we = v.we; cfg_pat = v.pat; cfg_len = v.len; cfg_ovl = v.ovl;
        din_vld = v.vld; din = v.din; cnt_clr = v.cclr;
        if (v.cclr) m2 = 0;
        else if (v.ez && m2 < 3) m2++;
        irq_m = v.ez ? 1'b1 : (irq_clr ? 1'b0 : irq_m);
        e.z = v.ez; e.a = v.ea; e.cnt = v.ecnt; e.cnt2 = m2; e.irq = irq_m;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("Z", {31'd0, z1}, {31'd0, e.z});
            chk("armed", {31'd0, a1}, {31'd0, e.a});
            chk("match_cnt", {24'd0, c1}, e.cnt);
            chk("Z_cnt2", {31'd0, z2}, {31'd0, e.z});
            chk("match_cnt2", {30'd0, c2}, e.cnt2);
`ifdef SEQ_DETECT_IRQ_EN
            chk("irq", {31'd0, q1}, {31'd0, e.irq});
`endif
        end
        @(negedge clk);
    endtask

    // Asynchronous reset between edges: outputs must clear without a clock.
    task automatic rst_pulse();
        #2 clr = 1'b0;
        #1;
        chk("rst_Z", {31'd0, z1}, 32'd0);
        chk("rst_armed", {31'd0, a1}, 32'd0);
        chk("rst_cnt", {24'd0, c1}, 32'd0);
        chk("rst_cnt2", {30'd0, c2}, 32'd0);
`ifdef SEQ_DETECT_IRQ_EN
        chk("rst_irq", {31'd0, q1}, 32'd0);
`endif
        m2 = 0;
        irq_m = 1'b0;
        @(posedge clk);
        #2 clr = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout step=%0d", step);
        $fatal(1, "timeout");
    end

    initial begin
        // Default pattern 01110, overlap
        tbl.push_back(D(0,0,0,0)); tbl.push_back(D(1,0,0,0)); tbl.push_back(D(1,0,0,0));
        tbl.push_back(D(1,0,0,0)); tbl.push_back(D(0,1,1,1)); tbl.push_back(G(0,1,1));
        // 101 len 3 overlap, then non-overlap
        tbl.push_back(C(8'h05,4'd3,1,1));
        tbl.push_back(D(1,0,0,1)); tbl.push_back(D(0,0,0,1)); tbl.push_back(D(1,1,1,2));
        tbl.push_back(D(0,0,1,2)); tbl.push_back(D(1,1,1,3));
        tbl.push_back(C(8'h05,4'd3,0,3));
        tbl.push_back(D(1,0,0,3)); tbl.push_back(D(0,0,0,3)); tbl.push_back(D(1,1,0,4));
        tbl.push_back(D(0,0,0,4)); tbl.push_back(D(1,0,0,4));
        // Gap of invalid cycles inside the pattern
        tbl.push_back(C(P0,4'd5,1,4));
        tbl.push_back(D(0,0,0,4)); tbl.push_back(D(1,0,0,4)); tbl.push_back(D(1,0,0,4));
        for (int i = 0; i < 4; i++) tbl.push_back(G(1,0,4));
        tbl.push_back(D(1,0,0,4)); tbl.push_back(D(0,1,1,5)); tbl.push_back(G(0,1,5));
        // Config write mid-pattern drops that bit and clears history
        tbl.push_back(D(0,0,1,5)); tbl.push_back(D(1,0,1,5)); tbl.push_back(D(1,0,1,5));
        tbl.push_back(C(P0,4'd5,1,5));
        tbl.push_back(D(1,0,0,5)); tbl.push_back(D(0,0,0,5)); tbl.push_back(D(0,0,0,5));
        tbl.push_back(D(1,0,0,5)); tbl.push_back(D(1,0,1,5)); tbl.push_back(D(1,0,1,5));
        tbl.push_back(D(0,1,1,6));
        // Oversized length clamps to the full history width
        tbl.push_back(C(8'hAA,4'd15,1,6));
        for (int i = 0; i < 7; i++) tbl.push_back(D(((i % 2) == 0), 0, 0, 6));
        tbl.push_back(D(0,1,1,7)); tbl.push_back(D(1,0,1,7)); tbl.push_back(D(0,1,1,8));
        // Length 1, non-overlap
        tbl.push_back(C(8'h01,4'd1,0,8));
        tbl.push_back(D(1,1,0,9)); tbl.push_back(D(0,0,1,9));
        tbl.push_back(D(1,1,0,10)); tbl.push_back(D(1,1,0,11));
        // Counter clear beats a same-cycle match
        tbl.push_back(C(P0,4'd5,1,11));
        tbl.push_back(D(0,0,0,11)); tbl.push_back(D(1,0,0,11)); tbl.push_back(D(1,0,0,11));
        tbl.push_back(D(1,0,0,11));
        tbl.push_back(V(0,8'h00,4'd0,0,1,0,1,1,1,0));
        tbl.push_back(G(0,1,0));
        tbl.push_back(D(0,0,1,0)); tbl.push_back(D(1,0,1,0)); tbl.push_back(D(1,0,1,0));
        tbl.push_back(D(1,0,1,0)); tbl.push_back(D(0,1,1,1));
        tbl.push_back(V(0,8'h00,4'd0,0,0,0,1,0,1,0));

        // Reset state, checked before any clock edge with reset held
        #1;
        chk("init_Z", {31'd0, z1}, 32'd0);
        chk("init_armed", {31'd0, a1}, 32'd0);
        chk("init_cnt", {24'd0, c1}, 32'd0);
        @(negedge clk);
        #2 clr = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) cyc(tbl[i]);

        // Length 0 disables detection entirely
        cyc(C(P0,4'd0,1,0));
        for (int i = 0; i < 100; i++) cyc(D(1'($urandom_range(0,1)),0,0,0));

        // Mid-stream reset: a 0 after reset must not complete the old 0111
        cyc(C(P0,4'd5,1,0));
        cyc(D(0,0,0,0)); cyc(D(1,0,0,0)); cyc(D(1,0,0,0)); cyc(D(1,0,0,0)); cyc(D(0,1,1,1));
        cyc(D(0,0,1,1)); cyc(D(1,0,1,1)); cyc(D(1,0,1,1)); cyc(D(1,0,1,1));
        rst_pulse();
        cyc(D(0,0,0,0)); cyc(D(1,0,0,0)); cyc(D(1,0,0,0)); cyc(D(1,0,0,0)); cyc(D(0,1,1,1));

        // Reset restores the default configuration after a disable
        cyc(C(P0,4'd0,0,1));
        rst_pulse();
        cyc(D(0,0,0,0)); cyc(D(1,0,0,0)); cyc(D(1,0,0,0)); cyc(D(1,0,0,0)); cyc(D(0,1,1,1));

        // Sticky irq: cleared alone, but a same-cycle match keeps it set
        irq_clr = 1'b1; cyc(G(0,1,1)); irq_clr = 1'b0;
        cyc(D(0,0,1,1)); cyc(D(1,0,1,1)); cyc(D(1,0,1,1)); cyc(D(1,0,1,1));
        irq_clr = 1'b1; cyc(D(0,1,1,2)); irq_clr = 1'b0;
        cyc(G(0,1,2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
